// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : UART receiver with 2-flop input synchronizer, 3-sample
//                majority voting per bit, optional parity, frame/parity error
//                flags and a single-entry holding register with sticky overrun.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_core #(
    parameter int BAUD_DIV   = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    input  logic                 clear_err
);

    localparam int c_PH_W = $clog2(BAUD_DIV);
    localparam int c_BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_PH_W-1:0] c_PH_A    = c_PH_W'(BAUD_DIV / 2 - 1);
    localparam logic [c_PH_W-1:0] c_PH_B    = c_PH_W'(BAUD_DIV / 2);
    localparam logic [c_PH_W-1:0] c_PH_DEC  = c_PH_W'(BAUD_DIV / 2 + 1);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(BAUD_DIV - 1);
    localparam logic [c_BC_W-1:0] c_BC_LAST = c_BC_W'(DATA_BITS - 1);
    localparam logic              c_PAR_EN  = (PARITY_EN != 0);
    localparam logic              c_PAR_ODD = (PARITY_ODD != 0);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HIGH = 3'd5;

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxs_prev;
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [c_PH_W-1:0]    r_phase;
    logic [c_BC_W-1:0]    r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_samp_a;
    logic                 r_samp_b;
    logic                 r_par_bit;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_rxs;
    logic w_decide;
    logic w_boundary;
    logic w_maj;
    logic w_complete;
    logic w_par_err;

    assign w_rxs      = r_sync2;
    assign w_decide   = (r_phase == c_PH_DEC);
    assign w_boundary = (r_phase == c_PH_LAST);
    // Third sample is the live value at the decision phase.
    assign w_maj      = (r_samp_a & r_samp_b) | (r_samp_a & w_rxs) | (r_samp_b & w_rxs);
    // Even parity: data ^ parity must be 0; odd parity: must be 1.
    assign w_par_err  = c_PAR_EN & ((^r_shift) ^ r_par_bit ^ c_PAR_ODD);

    // Two-flop synchronizer plus previous-value flop for falling-edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxs_prev <= r_sync2;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; w_complete marks the stop-bit decision cycle.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_rxs_prev && !w_rxs) w_state_next = c_ST_START;
            end
            c_ST_START: begin
                if (w_decide && w_maj)   w_state_next = c_ST_IDLE;
                else if (w_boundary)     w_state_next = c_ST_DATA;
            end
            c_ST_DATA: begin
                if (w_boundary && (r_bit_cnt == c_BC_LAST))
                    w_state_next = c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
            end
            c_ST_PARITY: begin
                if (w_boundary) w_state_next = c_ST_STOP;
            end
            c_ST_STOP: begin
                if (w_decide) begin
                    w_complete   = 1'b1;
                    w_state_next = w_maj ? c_ST_IDLE : c_ST_WAIT_HIGH;
                end
            end
            c_ST_WAIT_HIGH: begin
                if (w_rxs) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Bit-phase and bit counters, majority samples, data/parity capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_samp_a  <= 1'b0;
            r_samp_b  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            if ((w_state_next != r_state) || w_boundary ||
                (r_state == c_ST_IDLE) || (r_state == c_ST_WAIT_HIGH))
                r_phase <= '0;
            else
                r_phase <= r_phase + 1'b1;

            if (r_state != c_ST_DATA)
                r_bit_cnt <= '0;
            else if (w_boundary)
                r_bit_cnt <= r_bit_cnt + 1'b1;

            if (r_phase == c_PH_A) r_samp_a <= w_rxs;
            if (r_phase == c_PH_B) r_samp_b <= w_rxs;

            if ((r_state == c_ST_DATA) && w_decide)
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};

            if ((r_state == c_ST_PARITY) && w_decide)
                r_par_bit <= w_maj;
        end
    end

    // Holding register, handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_complete && (!r_valid || rx_ready)) begin
                r_data       <= r_shift;
                r_frame_err  <= ~w_maj;
                r_parity_err <= w_par_err;
                r_valid      <= 1'b1;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            if (w_complete && r_valid && !rx_ready)
                r_overrun <= 1'b1;
            else if (clear_err)
                r_overrun <= 1'b0;
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Self-checking bench for uart_rx_core (8N1 instance and an
//                8O1 instance), table-driven frames plus corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    localparam int c_BIT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd_m = 1'b1, rxd_p = 1'b1;
    logic       rx_ready_m = 1'b1, rx_ready_p = 1'b1;
    logic       clear_err = 1'b0, clear_err_p = 1'b0;
    logic [7:0] rx_data_m, rx_data_p;
    logic       rx_valid_m, rx_valid_p;
    logic       frame_err_m, frame_err_p;
    logic       parity_err_m, parity_err_p;
    logic       overrun_m, overrun_p;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int         acc_m = 0, acc_p = 0;
    logic [7:0] last_d_m, last_d_p;
    logic       last_fe_m, last_fe_p, last_pe_m, last_pe_p;
    int         last_cyc_m = 0, last_cyc_p = 0;

    uart_rx_core dut_m (
        .clk(clk), .reset(reset), .rxd(rxd_m), .rx_data(rx_data_m),
        .rx_valid(rx_valid_m), .rx_ready(rx_ready_m), .frame_err(frame_err_m),
        .parity_err(parity_err_m), .overrun(overrun_m), .clear_err(clear_err)
    );

    uart_rx_core #(.BAUD_DIV(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1)) dut_p (
        .clk(clk), .reset(reset), .rxd(rxd_p), .rx_data(rx_data_p),
        .rx_valid(rx_valid_p), .rx_ready(rx_ready_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun(overrun_p), .clear_err(clear_err_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted byte, seen half a cycle after the edge.
    always @(negedge clk) begin
        if (rx_valid_m && rx_ready_m) begin
            acc_m      <= acc_m + 1;
            last_d_m   <= rx_data_m;
            last_fe_m  <= frame_err_m;
            last_pe_m  <= parity_err_m;
            last_cyc_m <= cyc;
        end
        if (rx_valid_p && rx_ready_p) begin
            acc_p      <= acc_p + 1;
            last_d_p   <= rx_data_p;
            last_fe_p  <= frame_err_p;
            last_pe_p  <= parity_err_p;
            last_cyc_p <= cyc;
        end
    end

    typedef struct packed {
        logic       sel;       // 0 = 8N1 instance, 1 = 8O1 instance
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
        logic [8:0] exp_lat;   // posedges from rxd fall to rx_valid visible
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_line(input logic sel, input logic v);
        if (sel) rxd_p = v;
        else     rxd_m = v;
    endtask

    // Drive one frame; the line is left at the stop-bit value.
    task automatic send_frame(input logic sel, input logic [7:0] d, input logic haspar,
                              input logic par, input logic stop, output int t0);
        @(negedge clk);
        set_line(sel, 1'b0);
        t0 = cyc;
        repeat (c_BIT) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            set_line(sel, d[b]);
            repeat (c_BIT) @(negedge clk);
        end
        if (haspar) begin
            set_line(sel, par);
            repeat (c_BIT) @(negedge clk);
        end
        set_line(sel, stop);
        repeat (c_BIT) @(negedge clk);
    endtask

    initial begin
        int t0;
        int a0;

        //            sel  data   par   stop  exp_d  fe    pe    lat
        vecs[0] = '{1'b0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 9'd157};
        vecs[1] = '{1'b0, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 9'd157};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 9'd157};
        vecs[3] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 9'd157};
        vecs[4] = '{1'b0, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 9'd157};
        vecs[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 9'd173};
        vecs[6] = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 9'd173};
        vecs[7] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 9'd173};
        vecs[8] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 9'd173};
        vecs[9] = '{1'b1, 8'hC6, 1'b1, 1'b0, 8'hC6, 1'b1, 1'b0, 9'd173};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset rx_valid", {31'd0, rx_valid_m}, 32'd0);
        check("reset rx_data", {24'd0, rx_data_m}, 32'd0);
        check("reset frame_err", {31'd0, frame_err_m}, 32'd0);
        check("reset parity_err", {31'd0, parity_err_m}, 32'd0);
        check("reset overrun", {31'd0, overrun_m}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            a0 = vecs[i].sel ? acc_p : acc_m;
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].sel, vecs[i].par, vecs[i].stop, t0);
            set_line(vecs[i].sel, 1'b1);
            repeat (20) @(negedge clk);
            if (vecs[i].sel) begin
                check($sformatf("vec%0d count", i), acc_p - a0, 1);
                check($sformatf("vec%0d data", i), {24'd0, last_d_p}, {24'd0, vecs[i].exp_data});
                check($sformatf("vec%0d frame_err", i), {31'd0, last_fe_p}, {31'd0, vecs[i].exp_fe});
                check($sformatf("vec%0d parity_err", i), {31'd0, last_pe_p}, {31'd0, vecs[i].exp_pe});
                check($sformatf("vec%0d latency", i), last_cyc_p - t0, {23'd0, vecs[i].exp_lat});
            end else begin
                check($sformatf("vec%0d count", i), acc_m - a0, 1);
                check($sformatf("vec%0d data", i), {24'd0, last_d_m}, {24'd0, vecs[i].exp_data});
                check($sformatf("vec%0d frame_err", i), {31'd0, last_fe_m}, {31'd0, vecs[i].exp_fe});
                check($sformatf("vec%0d parity_err", i), {31'd0, last_pe_m}, {31'd0, vecs[i].exp_pe});
                check($sformatf("vec%0d latency", i), last_cyc_m - t0, {23'd0, vecs[i].exp_lat});
            end
        end

        // False start: 4-cycle low glitch, then a real frame 0xA3
        a0 = acc_m;
        @(negedge clk); rxd_m = 1'b0;
        repeat (4) @(negedge clk);
        rxd_m = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch no frame", acc_m - a0, 0);
        check("glitch rx_valid", {31'd0, rx_valid_m}, 32'd0);
        send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("after glitch count", acc_m - a0, 1);
        check("after glitch data", {24'd0, last_d_m}, 32'hA3);
        check("after glitch frame_err", {31'd0, last_fe_m}, 32'd0);

        // Stop bit 0 followed by a long low line: exactly one frame
        a0 = acc_m;
        send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, t0);
        repeat (2 * c_BIT) @(negedge clk);
        check("break count", acc_m - a0, 1);
        check("break data", {24'd0, last_d_m}, 32'h0F);
        check("break frame_err", {31'd0, last_fe_m}, 32'd1);
        rxd_m = 1'b1;
        repeat (40) @(negedge clk);
        check("break after high count", acc_m - a0, 1);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("post-break data", {24'd0, last_d_m}, 32'h3C);
        check("post-break frame_err", {31'd0, last_fe_m}, 32'd0);

        // Overrun: consumer stalled over two frames
        @(posedge clk); #2 rx_ready_m = 1'b0;
        a0 = acc_m;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("ovr first no overrun", {31'd0, overrun_m}, 32'd0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("ovr rx_valid", {31'd0, rx_valid_m}, 32'd1);
        check("ovr held data", {24'd0, rx_data_m}, 32'hA5);
        check("ovr overrun", {31'd0, overrun_m}, 32'd1);
        check("ovr none accepted", acc_m - a0, 0);
        @(posedge clk); #2 clear_err = 1'b1;
        @(posedge clk); #2 clear_err = 1'b0;
        @(negedge clk);
        check("clear_err overrun", {31'd0, overrun_m}, 32'd0);
        check("clear_err rx_valid kept", {31'd0, rx_valid_m}, 32'd1);
        @(posedge clk); #2 rx_ready_m = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr drain count", acc_m - a0, 1);
        check("ovr drain data", {24'd0, last_d_m}, 32'hA5);
        check("ovr drain rx_valid", {31'd0, rx_valid_m}, 32'd0);

        // Reset in the middle of 0xFF data, then 0x12
        @(negedge clk); rxd_m = 1'b0;
        repeat (c_BIT) @(negedge clk);
        rxd_m = 1'b1;
        repeat (3 * c_BIT) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid reset rx_data", {24'd0, rx_data_m}, 32'd0);
        check("mid reset rx_valid", {31'd0, rx_valid_m}, 32'd0);
        reset = 1'b0;
        a0 = acc_m;
        repeat (6 * c_BIT) @(negedge clk);
        check("post reset no frame", acc_m - a0, 0);
        send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, t0);
        repeat (20) @(negedge clk);
        check("post reset count", acc_m - a0, 1);
        check("post reset data", {24'd0, last_d_m}, 32'h12);
        check("post reset frame_err", {31'd0, last_fe_m}, 32'd0);
        check("post reset parity_err", {31'd0, last_pe_m}, 32'd0);
        check("post reset overrun", {31'd0, overrun_m}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
